// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; req/ack data-memory access with upstream stall.
// Optional MEM_ALIGN_CHECK_EN turns misaligned memory ops into a one-cycle misalign fault.
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rt,
  input  logic [4:0]  ex_dst,
  input  logic        ex_reg_write,
  input  logic        ex_mem_reg_dst,
  input  logic        ex_mem_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dst,
  output logic        wb_reg_write,
  output logic        misalign
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t      state_q;
  logic        req_q, we_q, wb_we_q, mis_q;
  logic [31:0] addr_q, wdata_q, wb_result_q;
  logic [4:0]  wb_dst_q;
  logic        mem_op, is_load, fault;
  assign mem_op  = ex_mem_write | ex_mem_reg_dst;
  assign is_load = ex_mem_reg_dst & ~ex_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign fault = mem_op & (|ex_alu[1:0]);
`else
  assign fault = 1'b0;
`endif
  assign stall = (state_q == S_IDLE) ? (mem_op & ~fault) : ~dmem_ack;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_result_q <= '0;
      wb_dst_q    <= '0;
      wb_we_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (fault) begin
          mis_q   <= 1'b1;
          wb_we_q <= 1'b0;
        end else if (mem_op) begin
          req_q   <= 1'b1;
          we_q    <= ex_mem_write;
          addr_q  <= {ex_alu[31:2], 2'b00};
          wdata_q <= ex_rt;
          wb_we_q <= 1'b0;
          state_q <= S_WAIT;
        end else begin
          wb_result_q <= ex_alu;
          wb_dst_q    <= ex_dst;
          wb_we_q     <= ex_reg_write;
        end
      end else if (dmem_ack) begin
        // a store that also claims load write-back returns the ALU value
        wb_result_q <= is_load ? dmem_rdata : ex_alu;
        wb_dst_q    <= ex_dst;
        wb_we_q     <= ex_reg_write;
        req_q       <= 1'b0;
        state_q     <= S_IDLE;
      end else begin
        wb_we_q <= 1'b0;
      end
    end
  end
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_result    = wb_result_q;
  assign wb_dst       = wb_dst_q;
  assign wb_reg_write = wb_we_q;
  assign misalign     = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; write-backs are checked by a monitor against a queue.
module tb_mem_stage;
  logic        clock = 0, reset = 1;
  logic [31:0] ex_alu = 0, ex_rt = 0, dmem_rdata = 0;
  logic [4:0]  ex_dst = 0;
  logic        ex_reg_write = 0, ex_mem_reg_dst = 0, ex_mem_write = 0, dmem_ack = 0;
  logic        stall, dmem_req, dmem_we, wb_reg_write, misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb_result;
  logic [4:0]  wb_dst;
  int vectors = 0, errors = 0;
  logic [36:0] sb[$];
  mem_stage dut (
    .clock(clock), .reset(reset), .ex_alu(ex_alu), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_reg_dst(ex_mem_reg_dst), .ex_mem_write(ex_mem_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_result(wb_result), .wb_dst(wb_dst), .wb_reg_write(wb_reg_write), .misalign(misalign)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask
  // every register write-back must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && wb_reg_write) begin
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_result", wb_result, e[36:5]);
        chk("wb_dst", {27'd0, wb_dst}, {27'd0, e[4:0]});
      end
    end
  end
  task automatic nop();
    ex_alu = 0; ex_rt = 0; ex_dst = 0; ex_reg_write = 0; ex_mem_reg_dst = 0; ex_mem_write = 0;
  endtask
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic alu(input logic [31:0] v, input logic [4:0] d, input logic spur_ack);
    nop(); ex_alu = v; ex_dst = d; ex_reg_write = 1; dmem_ack = spur_ack;
    sb.push_back({v, d});
    @(negedge clock);
    chk("alu_stall", {31'd0, stall}, 0);
    step();
    dmem_ack = 0;
    chk("alu_wb_result", wb_result, v);
    chk("alu_wb_we", {31'd0, wb_reg_write}, 1);
    chk("alu_req", {31'd0, dmem_req}, 0);
    nop();
  endtask
  task automatic mem(input logic st, input logic ld, input logic [31:0] a, input logic [31:0] rt,
                     input logic [4:0] d, input logic rw, input int n, input logic [31:0] rd,
                     input logic [31:0] exp_wb);
    int sc;
    nop(); ex_alu = a; ex_rt = rt; ex_dst = d; ex_reg_write = rw; ex_mem_write = st; ex_mem_reg_dst = ld;
    if (rw) sb.push_back({exp_wb, d});
    @(negedge clock); sc = stall;
    step();
    chk("req_up", {31'd0, dmem_req}, 1);
    chk("dmem_we", {31'd0, dmem_we}, {31'd0, st});
    chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
    chk("dmem_wdata", dmem_wdata, rt);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); sc += stall;
      chk("wait_wb_we", {31'd0, wb_reg_write}, 0);
      step();
      chk("req_hold", {31'd0, dmem_req}, 1);
      chk("addr_hold", dmem_addr, {a[31:2], 2'b00});
    end
    dmem_ack = 1; dmem_rdata = rd;
    @(negedge clock); sc += stall;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    chk("stall_cycles", sc, n + 1);
    chk("req_down", {31'd0, dmem_req}, 0);
    chk("mem_wb_we", {31'd0, wb_reg_write}, {31'd0, rw});
    if (rw) chk("mem_wb_result", wb_result, exp_wb);
    nop();
  endtask
  initial begin
    repeat (2) step();
    @(negedge clock);
    chk("rst_outs", {dmem_req, dmem_we, wb_reg_write, misalign}, 0);
    chk("rst_addr", dmem_addr | dmem_wdata | wb_result | {27'd0, wb_dst}, 0);
    step(); reset = 0;
    alu(32'h12345678, 5'd5, 0);
    step();
    mem(0, 1, 32'h100, 0, 5'd7, 1, 2, 32'hDEADBEEF, 32'hDEADBEEF);
    mem(1, 0, 32'h200, 32'hCAFEF00D, 5'd0, 0, 0, 32'h0, 32'h0);
    mem(1, 1, 32'h304, 32'h11112222, 5'd3, 1, 1, 32'h99999999, 32'h304);
    mem(0, 1, 32'h400, 0, 5'd9, 1, 3, 32'hA5A5A5A5, 32'hA5A5A5A5);
    alu(32'h00000404, 5'd10, 1);
    chk("after_spur_req", {31'd0, dmem_req}, 0);
    step();
    chk("spur_idle_wb_we", {31'd0, wb_reg_write}, 0);
    // reset in the middle of an outstanding access
    ex_alu = 32'h500; ex_dst = 5'd4; ex_reg_write = 1; ex_mem_reg_dst = 1;
    step(); step();
    chk("pre_rst_req", {31'd0, dmem_req}, 1);
    reset = 1; nop();
    step(); reset = 0;
    chk("rst_wait_req", {31'd0, dmem_req}, 0);
    chk("rst_wait_outs", {dmem_we, wb_reg_write, misalign}, 0);
    chk("rst_wait_data", dmem_addr | wb_result, 0);
    step(); dmem_ack = 1; dmem_rdata = 32'h77777777;
    @(negedge clock);
    chk("late_ack_stall", {31'd0, stall}, 0);
    step(); dmem_ack = 0;
    chk("late_ack_req", {31'd0, dmem_req}, 0);
    chk("late_ack_we", {31'd0, wb_reg_write}, 0);
    alu(32'hFEEDFACE, 5'd31, 0);
`ifdef MEM_ALIGN_CHECK_EN
    ex_alu = 32'h102; ex_dst = 5'd6; ex_reg_write = 1; ex_mem_reg_dst = 1;
    @(negedge clock);
    chk("mis_stall", {31'd0, stall}, 0);
    step(); nop();
    chk("mis_pulse", {31'd0, misalign}, 1);
    chk("mis_req", {31'd0, dmem_req}, 0);
    chk("mis_wb_we", {31'd0, wb_reg_write}, 0);
    step();
    chk("mis_clear", {31'd0, misalign}, 0);
`else
    mem(0, 1, 32'h102, 0, 5'd6, 1, 1, 32'h13572468, 32'h13572468);
    chk("no_misalign", {31'd0, misalign}, 0);
`endif
    step(); step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage consuming the EX/MEM pipeline register outputs and producing the MEM/WB register outputs. Drives a single-port data memory over a req/ack handshake of variable latency (shared with the VGA frame buffer arbiter), and asserts `stall` to freeze the upstream pipeline while an access is outstanding. Non-memory instructions pass through with one-cycle latency.

## Interface
Parameters:
- none (data width 32, register index 5, fixed).

Ports:
- `clock`  in  1  single clock, all state on posedge.
- `reset`  in  1  synchronous, active-high.
- `ex_alu`  in  32  ALU result; byte address for loads/stores.
- `ex_rt`  in  32  store data.
- `ex_dst`  in  5  destination register.
- `ex_reg_write`  in  1  instruction writes register file.
- `ex_mem_reg_dst`  in  1  load: write-back takes memory data.
- `ex_mem_write`  in  1  store.
- `stall`  out  1  combinational; high means upstream must hold EX/MEM contents.
- `dmem_req`  out  1  registered access request.
- `dmem_we`  out  1  registered; 1 = write.
- `dmem_addr`  out  32  registered word address, `{ex_alu[31:2],2'b00}`.
- `dmem_wdata`  out  32  registered store data.
- `dmem_rdata`  in  32  read data, valid in the `dmem_ack` cycle.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `wb_result`  out  32  registered write-back data.
- `wb_dst`  out  5  registered destination.
- `wb_reg_write`  out  1  registered write enable to register file.
- `misalign`  out  1  registered one-cycle fault pulse (see Configuration).

## Operation
- `mem_op = ex_mem_write | ex_mem_reg_dst`.
- FSM states: IDLE, WAIT.
- IDLE, `mem_op`=0: load MEM/WB with `ex_alu`, `ex_dst`, `ex_reg_write`; `stall`=0; stay IDLE.
- IDLE, `mem_op`=1: `stall`=1; register `dmem_req`=1, `dmem_we`=`ex_mem_write`, address, wdata; `wb_reg_write`<=0 (bubble); go WAIT.
- WAIT, `dmem_ack`=0: `stall`=1; hold all `dmem_*` outputs stable; `wb_reg_write`<=0; stay WAIT.
- WAIT, `dmem_ack`=1: `stall`=0; MEM/WB loads `wb_result` = `dmem_rdata` if load, else `ex_alu`; `wb_dst`=`ex_dst`; `wb_reg_write`=`ex_reg_write`; `dmem_req`<=0; go IDLE.
- Both `ex_mem_write` and `ex_mem_reg_dst` set: treated as store; `wb_result`=`ex_alu`.
- `dmem_ack` while IDLE is ignored.
- `stall` = (IDLE & `mem_op` & !fault) | (WAIT & !`dmem_ack`).
- Reset: state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `wb_result`, `wb_dst`, `wb_reg_write`, `misalign` all 0. Reset during WAIT abandons the access; `dmem_req` is 0 the following cycle, late acks are ignored.

## Timing
- Non-memory op: latency 1 cycle, zero stall.
- Memory op, ack N cycles after `dmem_req` rises (N>=0 counted within WAIT): `stall` high for N+1 cycles; result visible at `wb_*` 1 cycle after ack; minimum 2 cycles through the stage.
- `dmem_req` deasserts the cycle after ack; a following memory op issues a new request no earlier than 1 cycle later (request gap of at least 1 cycle).
- `stall` is combinational from current state, `ex_*` inputs and `dmem_ack`; no other output is combinational.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: memory op in IDLE with `ex_alu[1:0]`!=0 issues no request, does not stall, pulses `misalign`=1 for one cycle, forces `wb_reg_write`<=0, stays IDLE.
- Undefined: `ex_alu[1:0]` ignored (address truncated), access proceeds; `misalign` held 0.

## Test plan
- ALU op `ex_alu`=0x12345678, dst=5, reg_write=1 -> next cycle `wb_result`=0x12345678, `wb_dst`=5, `wb_reg_write`=1; `stall` never high.
- Load addr 0x100, ack 2 cycles after `dmem_req` rises with rdata 0xDEADBEEF -> `stall` high 3 cycles, `dmem_we`=0, `dmem_addr`=0x100, then `wb_result`=0xDEADBEEF, `wb_reg_write`=1; `wb_reg_write`=0 during stall.
- Store addr 0x200, rt 0xCAFEF00D, ack in first WAIT cycle -> `dmem_we`=1, `dmem_wdata`=0xCAFEF00D, `stall` high exactly 1 cycle, `wb_reg_write`=0.
- Load followed by dependent ALU op -> ALU op held during stall, emerges at `wb_*` exactly one cycle after load result; spurious ack in IDLE causes no change.
- Reset asserted in WAIT, ack arrives 2 cycles later -> all outputs 0, `dmem_req`=0 the cycle after reset, ack ignored, state IDLE.
- With `MEM_ALIGN_CHECK_EN`: load addr 0x102 -> no `dmem_req`, `misalign`=1 for one cycle, `wb_reg_write`=0, `stall`=0; without macro: request issued with `dmem_addr`=0x100.
